// File: rtl/sift_stream_host_pkg.sv
// Shared definitions for the SIFT stream host: transfer FSM states and default widths.
package sift_stream_host_pkg;

    localparam int unsigned DEF_DATA_W  = 32;
    localparam int unsigned DEF_LEN_W   = 16;
    localparam int unsigned DEF_FIFO_AW = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_RECV = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/sift_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with full/empty flags.
module sift_sync_fifo
    import sift_stream_host_pkg::*;
#(
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned FIFO_AW = DEF_FIFO_AW
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              rd_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              full_o,
    output logic              empty_o
);

    localparam int unsigned DEPTH = 2 ** FIFO_AW;

    logic [DATA_W-1:0]  mem_q [DEPTH];
    logic [FIFO_AW:0]   wptr_q, wptr_d;
    logic [FIFO_AW:0]   rptr_q, rptr_d;
    logic               push, pop;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[FIFO_AW] != rptr_q[FIFO_AW]) &&
                     (wptr_q[FIFO_AW-1:0] == rptr_q[FIFO_AW-1:0]);

    // A pop frees the head slot in the same cycle, so a full FIFO still takes the push.
    assign push = wr_i && (!full_o || rd_i);
    assign pop  = rd_i && !empty_o;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push) wptr_d = wptr_q + (FIFO_AW+1)'(1);
        if (pop)  rptr_d = rptr_q + (FIFO_AW+1)'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wptr_q[FIFO_AW-1:0]] <= wdata_i;
    end

    assign rdata_o = empty_o ? '0 : mem_q[rptr_q[FIFO_AW-1:0]];

endmodule

// File: rtl/sift_stream_host.sv
// Host side of the SIFT core stream pair: sends one tlast-terminated frame from the
// TX FIFO, then collects a fixed count of result words into the RX FIFO.
module sift_stream_host
    import sift_stream_host_pkg::*;
#(
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned FIFO_AW = DEF_FIFO_AW,
    parameter int unsigned LEN_W   = DEF_LEN_W
) (
    input  logic              axis_clk_i,
    input  logic              axis_rst_i,
    input  logic              start_i,
    input  logic [LEN_W-1:0]  tx_len_i,
    input  logic [LEN_W-1:0]  rx_len_i,
    input  logic              tx_wr_i,
    input  logic [DATA_W-1:0] tx_wdata_i,
    output logic              tx_full_o,
    input  logic              rx_rd_i,
    output logic [DATA_W-1:0] rx_rdata_o,
    output logic              rx_empty_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    input  logic              mem_ovfl_i,
    output logic              m_axis_tvalid_o,
    input  logic              m_axis_tready_i,
    output logic              m_axis_tlast_o,
    output logic [DATA_W-1:0] m_axis_tdata_o,
    input  logic              s_axis_tvalid_i,
    output logic              s_axis_tready_o,
    input  logic [DATA_W-1:0] s_axis_tdata_i
);

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   tx_len_q, tx_len_d;
    logic [LEN_W-1:0]   rx_len_q, rx_len_d;
    logic [LEN_W-1:0]   tx_cnt_q, tx_cnt_d;
    logic [LEN_W-1:0]   rx_cnt_q, rx_cnt_d;
    logic               err_q, err_d;

    logic               tx_pop, tx_empty;
    logic [DATA_W-1:0]  tx_head;
    logic               rx_push, rx_full;

    sift_sync_fifo #(
        .DATA_W  (DATA_W),
        .FIFO_AW (FIFO_AW)
    ) u_tx_fifo (
        .clk_i   (axis_clk_i),
        .rst_i   (axis_rst_i),
        .wr_i    (tx_wr_i),
        .wdata_i (tx_wdata_i),
        .rd_i    (tx_pop),
        .rdata_o (tx_head),
        .full_o  (tx_full_o),
        .empty_o (tx_empty)
    );

    sift_sync_fifo #(
        .DATA_W  (DATA_W),
        .FIFO_AW (FIFO_AW)
    ) u_rx_fifo (
        .clk_i   (axis_clk_i),
        .rst_i   (axis_rst_i),
        .wr_i    (rx_push),
        .wdata_i (s_axis_tdata_i),
        .rd_i    (rx_rd_i),
        .rdata_o (rx_rdata_o),
        .full_o  (rx_full),
        .empty_o (rx_empty_o)
    );

    always_comb begin
        state_d         = state_q;
        tx_len_d        = tx_len_q;
        rx_len_d        = rx_len_q;
        tx_cnt_d        = tx_cnt_q;
        rx_cnt_d        = rx_cnt_q;
        err_d           = err_q;
        m_axis_tvalid_o = 1'b0;
        m_axis_tlast_o  = 1'b0;
        s_axis_tready_o = 1'b0;
        busy_o          = 1'b0;
        done_o          = 1'b0;
        tx_pop          = 1'b0;
        rx_push         = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    err_d    = 1'b0;
                    tx_len_d = tx_len_i;
                    rx_len_d = rx_len_i;
                    tx_cnt_d = '0;
                    rx_cnt_d = '0;
                    if (tx_len_i == '0 || rx_len_i == '0) err_d   = 1'b1;
                    else                                  state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                busy_o = 1'b1;
                // Overflow drops the handshake in the same cycle so no word is lost.
                if (mem_ovfl_i) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    m_axis_tvalid_o = !tx_empty;
                    m_axis_tlast_o  = m_axis_tvalid_o && (tx_cnt_q == tx_len_q - LEN_W'(1));
                    if (m_axis_tvalid_o && m_axis_tready_i) begin
                        tx_pop   = 1'b1;
                        tx_cnt_d = tx_cnt_q + LEN_W'(1);
                        if (m_axis_tlast_o) state_d = ST_RECV;
                    end
                end
            end
            ST_RECV: begin
                busy_o = 1'b1;
                if (mem_ovfl_i) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    s_axis_tready_o = !rx_full;
                    if (s_axis_tready_o && s_axis_tvalid_i) begin
                        rx_push  = 1'b1;
                        rx_cnt_d = rx_cnt_q + LEN_W'(1);
                        if (rx_cnt_q == rx_len_q - LEN_W'(1)) state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                done_o  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign m_axis_tdata_o = m_axis_tvalid_o ? tx_head : '0;
    assign err_o          = err_q;

    always_ff @(posedge axis_clk_i) begin
        if (axis_rst_i) begin
            state_q  <= ST_IDLE;
            tx_len_q <= '0;
            rx_len_q <= '0;
            tx_cnt_q <= '0;
            rx_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            tx_len_q <= tx_len_d;
            rx_len_q <= rx_len_d;
            tx_cnt_q <= tx_cnt_d;
            rx_cnt_q <= rx_cnt_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_sift_stream_host.sv
// Scoreboard bench for sift_stream_host with small (4-word) FIFOs to exercise backpressure.
module tb_sift_stream_host;

    localparam int DW = 32;
    localparam int AW = 2;
    localparam int LW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [LW-1:0] txl = '0, rxl = '0;
    logic          tx_wr = 1'b0;
    logic [DW-1:0] tx_wdata = '0;
    logic          tx_full;
    logic          rx_rd = 1'b0;
    logic [DW-1:0] rx_rdata;
    logic          rx_empty, busy, done, err;
    logic          ovfl = 1'b0;
    logic          m_tvalid, m_tlast;
    logic          m_tready = 1'b0;
    logic [DW-1:0] m_tdata;
    logic          s_tvalid = 1'b0;
    logic          s_tready;
    logic [DW-1:0] s_tdata = '0;

    always #5 clk = ~clk;

    sift_stream_host #(
        .DATA_W  (DW),
        .FIFO_AW (AW),
        .LEN_W   (LW)
    ) dut (
        .axis_clk_i      (clk),
        .axis_rst_i      (rst),
        .start_i         (start),
        .tx_len_i        (txl),
        .rx_len_i        (rxl),
        .tx_wr_i         (tx_wr),
        .tx_wdata_i      (tx_wdata),
        .tx_full_o       (tx_full),
        .rx_rd_i         (rx_rd),
        .rx_rdata_o      (rx_rdata),
        .rx_empty_o      (rx_empty),
        .busy_o          (busy),
        .done_o          (done),
        .err_o           (err),
        .mem_ovfl_i      (ovfl),
        .m_axis_tvalid_o (m_tvalid),
        .m_axis_tready_i (m_tready),
        .m_axis_tlast_o  (m_tlast),
        .m_axis_tdata_o  (m_tdata),
        .s_axis_tvalid_i (s_tvalid),
        .s_axis_tready_o (s_tready),
        .s_axis_tdata_i  (s_tdata)
    );

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    endtask

    // Reference model: host-visible FIFO contents and per-transfer beat bookkeeping.
    logic [DW-1:0] tx_m[$];
    logic [DW-1:0] rx_m[$];
    int tx_total = 0, rx_total = 0, done_total = 0;
    int tx_base = 0, rx_base = 0, tx_len_m = 0, rx_len_m = 0;
    int tr_mode = 0;

    initial forever begin
        @(posedge clk); #1;
        case (tr_mode)
            0:       m_tready = 1'b1;
            1:       m_tready = ~m_tready;
            default: m_tready = 1'($urandom_range(0, 1));
        endcase
    end

    initial begin : monitor
        bit            prev_v = 0, prev_r = 0, prev_l = 0, done_due = 0;
        logic [DW-1:0] prev_d = '0;
        logic [DW-1:0] w;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_v   = 0;
                done_due = 0;
                continue;
            end
            if (prev_v && !prev_r && !ovfl)
                chk("tx_hold", {31'd0, m_tvalid, m_tlast, m_tdata}, {31'd0, 1'b1, prev_l, prev_d});
            if (m_tvalid && m_tready) begin
                if (tx_m.size() == 0) chk("tx_extra_beat", 64'd1, 64'd0);
                else begin
                    w = tx_m.pop_front();
                    chk("tx_data", 64'(m_tdata), 64'(w));
                    chk("tx_last", 64'(m_tlast), 64'(tx_total - tx_base == tx_len_m - 1));
                end
                tx_total++;
            end
            prev_v = m_tvalid; prev_r = m_tready; prev_l = m_tlast; prev_d = m_tdata;

            if (done || done_due) chk("done_pulse", 64'(done), 64'(done_due));
            if (done) done_total++;
            done_due = 0;
            if (s_tvalid && s_tready) begin
                rx_total++;
                if (rx_total - rx_base == rx_len_m) done_due = 1;
            end

            if (rx_rd && !rx_empty) begin
                if (rx_m.size() == 0) chk("rx_extra_pop", 64'd1, 64'd0);
                else begin
                    w = rx_m.pop_front();
                    chk("rx_data", 64'(rx_rdata), 64'(w));
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic push_word(input logic [DW-1:0] w);
        int g = 0;
        while (tx_full && g < 300) begin cyc(1); g++; end
        if (g >= 300) chk("tx_full_timeout", 64'd1, 64'd0);
        tx_wr = 1'b1; tx_wdata = w;
        tx_m.push_back(w);
        cyc(1);
        tx_wr = 1'b0;
    endtask

    task automatic do_start(input int a, input int b);
        tx_base = tx_total; rx_base = rx_total;
        tx_len_m = a; rx_len_m = b;
        start = 1'b1; txl = LW'(a); rxl = LW'(b);
        cyc(1);
        start = 1'b0;
    endtask

    task automatic core_send(input logic [DW-1:0] w);
        int  g = 0;
        bit  acc;
        s_tvalid = 1'b1; s_tdata = w;
        rx_m.push_back(w);
        forever begin
            @(negedge clk); acc = s_tready;
            cyc(1);
            if (acc) break;
            g++;
            if (g > 400) begin chk("rx_accept_timeout", 64'd0, 64'd1); break; end
        end
        s_tvalid = 1'b0;
    endtask

    task automatic host_read(input int n, input bit gaps);
        int g = 0, cnt = 0;
        while (cnt < n && g < 800) begin
            rx_rd = !rx_empty && (!gaps || $urandom_range(0, 1) == 1);
            if (rx_rd) cnt++;
            cyc(1);
            g++;
        end
        rx_rd = 1'b0;
        if (cnt < n) chk("rx_read_timeout", 64'(cnt), 64'(n));
    endtask

    task automatic wait_done(input int base, input int limit);
        int g = 0;
        while (done_total == base && g < limit) begin cyc(1); g++; end
        chk("done_seen", 64'(done_total), 64'(base + 1));
    endtask

    task automatic wait_tx(input int n, output int cycles);
        cycles = 0;
        while (tx_total - tx_base < n && cycles < 60) begin cyc(1); cycles++; end
        chk("tx_beats_reached", 64'(tx_total - tx_base), 64'(n));
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int c, d0, tl, rl;
        cyc(3);
        @(negedge clk);
        chk("rst_tvalid", 64'(m_tvalid), 64'd0);
        chk("rst_tlast",  64'(m_tlast),  64'd0);
        chk("rst_tready", 64'(s_tready), 64'd0);
        chk("rst_busy",   64'(busy),     64'd0);
        chk("rst_done",   64'(done),     64'd0);
        chk("rst_err",    64'(err),      64'd0);
        chk("rst_txfull", 64'(tx_full),  64'd0);
        chk("rst_rxempty",64'(rx_empty), 64'd1);
        chk("rst_tdata",  64'(m_tdata),  64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        cyc(2);

        // Back-to-back frame with tlast on the final word, then two results.
        tr_mode = 0;
        push_word(32'h11); push_word(32'h22); push_word(32'h33); push_word(32'h44);
        chk("tx_full_at_depth", 64'(tx_full), 64'd1);
        do_start(4, 2);
        chk("busy_in_send", 64'(busy), 64'd1);
        wait_tx(4, c);
        chk("tx_burst_cycles", 64'(c), 64'd4);
        d0 = done_total;
        core_send(32'hA5); core_send(32'h5A);
        wait_done(d0, 20);
        host_read(2, 0);
        chk("rx_drained_empty", 64'(rx_empty), 64'd1);
        chk("idle_not_busy", 64'(busy), 64'd0);

        // Same frame under alternating tready.
        tr_mode = 1;
        push_word(32'h11); push_word(32'h22); push_word(32'h33); push_word(32'h44);
        do_start(4, 2);
        wait_tx(4, c);
        cyc(3);
        chk("tx_exact_beats", 64'(tx_total - tx_base), 64'd4);
        d0 = done_total;
        core_send($urandom); core_send($urandom);
        wait_done(d0, 20);
        host_read(2, 0);
        tr_mode = 0;

        // Zero length is rejected; the next valid start clears the error.
        push_word(32'h77);
        do_start(0, 3);
        cyc(1);
        chk("zero_len_err",    64'(err),      64'd1);
        chk("zero_len_busy",   64'(busy),     64'd0);
        chk("zero_len_tvalid", 64'(m_tvalid), 64'd0);
        chk("zero_len_no_tx",  64'(tx_total - tx_base), 64'd0);
        do_start(1, 1);
        chk("err_cleared", 64'(err), 64'd0);
        d0 = done_total;
        core_send(32'hC3);
        wait_done(d0, 20);
        host_read(1, 0);

        // Overflow after two beats aborts and keeps the rest of the frame.
        push_word(32'h11); push_word(32'h22); push_word(32'h33); push_word(32'h44);
        d0 = done_total;
        do_start(4, 4);
        wait_tx(2, c);
        ovfl = 1'b1;
        cyc(1);
        ovfl = 1'b0;
        chk("ovfl_tvalid", 64'(m_tvalid), 64'd0);
        chk("ovfl_busy",   64'(busy),     64'd0);
        chk("ovfl_err",    64'(err),      64'd1);
        cyc(3);
        chk("ovfl_no_done", 64'(done_total), 64'(d0));
        chk("ovfl_beats",   64'(tx_total - tx_base), 64'd2);
        chk("ovfl_tx_kept", 64'(tx_m.size()), 64'd2);
        do_start(2, 1);
        wait_tx(2, c);
        d0 = done_total;
        core_send(32'hE1);
        wait_done(d0, 20);
        host_read(1, 0);

        // RX backpressure: six results into a four-deep FIFO with no host reads.
        push_word(32'h66);
        do_start(1, 6);
        wait_tx(1, c);
        d0 = done_total;
        fork
            begin
                for (int i = 0; i < 6; i++) core_send($urandom);
            end
        join_none
        cyc(20);
        chk("rx_bp_tready", 64'(s_tready), 64'd0);
        chk("rx_bp_beats",  64'(rx_total - rx_base), 64'd4);
        chk("rx_bp_busy",   64'(busy), 64'd1);
        host_read(2, 0);
        wait_done(d0, 60);
        chk("rx_bp_all", 64'(rx_total - rx_base), 64'd6);
        host_read(4, 0);
        chk("rx_bp_empty", 64'(rx_empty), 64'd1);

        // Reset mid-transfer returns everything to reset values with no done/err.
        push_word(32'h91); push_word(32'h92);
        d0 = done_total;
        do_start(2, 1);
        wait_tx(1, c);
        rst = 1'b1;
        cyc(2);
        tx_m.delete(); rx_m.delete();
        chk("mid_rst_busy",   64'(busy),     64'd0);
        chk("mid_rst_err",    64'(err),      64'd0);
        chk("mid_rst_empty",  64'(rx_empty), 64'd1);
        chk("mid_rst_tvalid", 64'(m_tvalid), 64'd0);
        rst = 1'b0;
        cyc(2);
        chk("mid_rst_no_done", 64'(done_total), 64'(d0));

        // Random transfers with concurrent host traffic and random tready.
        tr_mode = 2;
        for (int it = 0; it < 8; it++) begin
            tl = $urandom_range(1, 10);
            rl = $urandom_range(1, 10);
            d0 = done_total;
            do_start(tl, rl);
            fork
                begin
                    for (int i = 0; i < tl; i++) push_word($urandom);
                end
                begin
                    for (int i = 0; i < rl; i++) core_send($urandom);
                end
                host_read(rl, 1);
            join
            cyc(3);
            chk("rand_done", 64'(done_total), 64'(d0 + 1));
            chk("rand_tx_beats", 64'(tx_total - tx_base), 64'(tl));
        end

        cyc(3);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
